// File: rtl/array_function_checker_if.sv
// Command/response snoop bundle between the compute array bench and array_function_checker.
interface array_function_checker_if;
    logic [1:0]  op_code;
    logic [8:0]  addr;
    logic [15:0] data_bank;
    logic [15:0] data_in;
    logic [15:0] dut_result;
    logic        run_done;

    modport master (
        output op_code, addr, data_bank, data_in, dut_result, run_done
    );

    modport slave (
        input op_code, addr, data_bank, data_in, dut_result, run_done
    );
endinterface

// File: rtl/array_function_checker.sv
// Shadow-model response checker for the compute array command port.
// Optional mismatch/summary logging is enabled with `define ARRAY_CHK_LOG_EN.
module array_function_checker #(
    parameter int unsigned RESULT_LAT = 1,
    parameter int unsigned MAX_ERR    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    array_function_checker_if.slave    cmd,
    output logic [15:0]                cmd_cnt,
    output logic [7:0]                 err_cnt,
    output logic                       first_err_valid,
    output logic [15:0]                first_err_exp,
    output logic [15:0]                first_err_got,
    output logic [15:0]                first_err_idx,
    output logic                       pass,
    output logic                       done
);

    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SEARCH = 2'b10, OP_NOP = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                       state_q, state_d;
    logic [2:0]                   drain_q, drain_d;
    logic [7:0]                   mem [16][4];
    logic [RESULT_LAT-1:0]        pipe_v;
    logic [RESULT_LAT-1:0][15:0]  pipe_e;

    logic        sample, is_write, sched;
    logic [1:0]  row;
    logic [2:0]  col;
    logic [15:0] exp_now;
    logic        chk_vld, chk_err;
    logic [15:0] cmd_d;
    logic [7:0]  err_d;
    logic        unused_din;

    assign unused_din = ^cmd.data_in[15:8];
    assign row      = cmd.addr[4:3];
    assign col      = cmd.addr[2:0];
    assign sample   = (state_q == IDLE || state_q == RUN) && (cmd.op_code != OP_NOP);
    assign is_write = sample && (cmd.op_code == OP_WRITE);
    assign sched    = sample && (cmd.op_code != OP_WRITE);

    // Prediction uses pre-edge shadow contents.
    always_comb begin
        exp_now = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            if (cmd.op_code == OP_SEARCH)
                exp_now[b] = ({mem[b[3:0]][3][col], mem[b[3:0]][2][col],
                               mem[b[3:0]][1][col], mem[b[3:0]][0][col]} == cmd.data_bank[3:0]);
            else
                exp_now[b] = (^(mem[b[3:0]][row] & cmd.data_in[7:0])) ^ cmd.data_bank[b];
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (cmd.run_done)
                    state_d = DONE;
                else if (cmd.op_code != OP_NOP)
                    state_d = RUN;
            end
            RUN: begin
                if (cmd.run_done) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == 3'(RESULT_LAT - 1))
                    state_d = DONE;
                else
                    drain_d = drain_q + 3'd1;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chk_vld = pipe_v[RESULT_LAT-1];
        chk_err = chk_vld && (cmd.dut_result != pipe_e[RESULT_LAT-1]);
        cmd_d   = cmd_cnt + {15'd0, chk_vld};
        err_d   = err_cnt;
        if (chk_err && (err_cnt < 8'(MAX_ERR)))
            err_d = err_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            drain_q         <= '0;
            pipe_v          <= '0;
            pipe_e          <= '0;
            for (int unsigned b = 0; b < 16; b++)
                for (int unsigned r = 0; r < 4; r++)
                    mem[b[3:0]][r[1:0]] <= '0;
            cmd_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            first_err_idx   <= '0;
            pass            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            pipe_v[0] <= sched;
            pipe_e[0] <= exp_now;
            for (int unsigned i = 1; i < RESULT_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
            if (is_write)
                mem[cmd.addr[8:5]][row] <= cmd.data_bank[7:0];
            cmd_cnt <= cmd_d;
            err_cnt <= err_d;
            if (chk_err && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_exp   <= pipe_e[RESULT_LAT-1];
                first_err_got   <= cmd.dut_result;
                first_err_idx   <= cmd_cnt;
            end
            // Registered on DONE entry from next-cycle counts so pass is valid with done.
            done <= (state_d == DONE);
            pass <= (state_d == DONE) && (err_d == '0) && (cmd_d != '0);
        end
    end

`ifdef ARRAY_CHK_LOG_EN
    logic [RESULT_LAT-1:0][1:0] pipe_op;
    logic [RESULT_LAT-1:0][8:0] pipe_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_op   <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_op[0]   <= cmd.op_code;
            pipe_addr[0] <= cmd.addr;
            for (int unsigned i = 1; i < RESULT_LAT; i++) begin
                pipe_op[i]   <= pipe_op[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
            if (chk_err)
                $display("%0t array_chk mismatch op=%0d addr=%h exp=%h got=%h", $time,
                         pipe_op[RESULT_LAT-1], pipe_addr[RESULT_LAT-1],
                         pipe_e[RESULT_LAT-1], cmd.dut_result);
            if (state_d == DONE && state_q != DONE)
                $display("%0t array_chk %s cmds=%0d errs=%0d", $time,
                         ((err_d == '0) && (cmd_d != '0)) ? "PASS" : "FAIL", cmd_d, err_d);
        end
    end
`endif

endmodule
